mano_timing_sequencer: RTL and testbench

- Generates the timing signals T[7:0] and the registered opcode decode D[7:0] for the basic-computer control unit.
- The IR/AR/PC/AC control-logic blocks consume these signals as inputs.
- Contains the run flip-flop S, the sequence counter SC with its one-hot decoder, and the opcode/indirect capture registers (D, I).
- Sits between the instruction register and every register's LD/CLR/INC logic.

---
 rtl/mano_timing_sequencer.sv | 100 ++++++++++
 tb/tb_mano_timing_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mano_timing_sequencer.sv
// rtl/mano_timing_sequencer.sv - basic-computer timing sequencer (S flip-flop, SC, T decode, D/I capture)
//
// Purpose: produces the one-hot timing signals T and the registered opcode
// decode D / indirect bit I consumed by the register control logic.
//
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   start      - one-cycle pulse: sets S, clears sc_overrun
//   hlt        - HLT executed: clears S and SC
//   sc_clr     - end of instruction: SC <- 0 at next edge
//   ir         - instruction register contents
//   run        - S flip-flop value
//   sc         - current sequence count
//   T          - one-hot timing signals, all-zero while run=0
//   D          - registered one-hot opcode decode
//   I          - registered indirect bit
//   sc_overrun - sticky: SC wrapped from its maximum without sc_clr
module mano_timing_sequencer #(
    parameter int SC_BITS = 3,
    parameter int OPC_LSB = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    hlt,
    input  logic                    sc_clr,
    input  logic [15:0]             ir,
    output logic                    run,
    output logic [SC_BITS-1:0]      sc,
    output logic [(2**SC_BITS)-1:0] T,
    output logic [7:0]              D,
    output logic                    I,
    output logic                    sc_overrun
);

    localparam int TW = 2**SC_BITS;

    logic               s_q;
    logic [SC_BITS-1:0] sc_q;
    logic [7:0]         d_q;
    logic               i_q;
    logic               ovr_q;

    logic capture;
    logic overrun_hit;

    // Opcode/indirect are latched on the last T2 edge; IR was loaded at end of T1.
    assign capture     = s_q && (sc_q == SC_BITS'(2));
    // SC about to wrap from its maximum without an end-of-instruction or halt.
    assign overrun_hit = s_q && (sc_q == '1) && !sc_clr && !hlt;

    // Only the opcode field and the indirect bit are decoded here.
    logic unused_ir;
    assign unused_ir = ^(ir & ~(16'h8000 | (16'h0007 << OPC_LSB)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q   <= 1'b0;
            sc_q  <= '0;
            d_q   <= 8'h00;
            i_q   <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            // Run flip-flop: hlt has priority over start.
            if (hlt) begin
                s_q <= 1'b0;
            end else if (start) begin
                s_q <= 1'b1;
            end

            // While stopped SC sits at 0, so the first cycle after start is T0.
            if (!s_q || hlt || sc_clr) begin
                sc_q <= '0;
            end else begin
                sc_q <= sc_q + 1'b1;
            end

            if (capture) begin
                d_q <= 8'(1) << ir[OPC_LSB+2:OPC_LSB];
                i_q <= ir[15];
            end

            // A wrap on the same edge as a running-start still records the overrun.
            if (overrun_hit) begin
                ovr_q <= 1'b1;
            end else if (start) begin
                ovr_q <= 1'b0;
            end
        end
    end

    assign run        = s_q;
    assign sc         = sc_q;
    assign T          = s_q ? (TW'(1) << sc_q) : '0;
    assign D          = d_q;
    assign I          = i_q;
    assign sc_overrun = ovr_q;

endmodule

// File: tb/tb_mano_timing_sequencer.sv
// tb/tb_mano_timing_sequencer.sv - scoreboard bench for mano_timing_sequencer
module tb_mano_timing_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        hlt;
    logic        sc_clr;
    logic [15:0] ir;
    logic        run;
    logic [2:0]  sc;
    logic [7:0]  T;
    logic [7:0]  D;
    logic        I;
    logic        sc_overrun;

    mano_timing_sequencer #(.SC_BITS(3), .OPC_LSB(12)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .hlt        (hlt),
        .sc_clr     (sc_clr),
        .ir         (ir),
        .run        (run),
        .sc         (sc),
        .T          (T),
        .D          (D),
        .I          (I),
        .sc_overrun (sc_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic       run;
        logic [2:0] sc;
        logic [7:0] t;
        logic [7:0] d;
        logic       i;
        logic       ovr;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Monitor: pops each expected record as soon as it is posted and compares.
    initial begin
        forever begin
            wait (sb.size() != 0);
            mon_e = sb.pop_front();
            checks++;
            if ({run, sc, T, D, I, sc_overrun} !==
                {mon_e.run, mon_e.sc, mon_e.t, mon_e.d, mon_e.i, mon_e.ovr}) begin
                errors++;
                $display("FAIL %s: got run=%0b sc=%0d T=%h D=%h I=%0b ovr=%0b, want run=%0b sc=%0d T=%h D=%h I=%0b ovr=%0b",
                         mon_e.tag, run, sc, T, D, I, sc_overrun,
                         mon_e.run, mon_e.sc, mon_e.t, mon_e.d, mon_e.i, mon_e.ovr);
            end
        end
    end

    task automatic post(input string tag, input logic r, input logic [2:0] s,
                        input logic [7:0] t, input logic [7:0] d,
                        input logic i, input logic o);
        exp_t e;
        e.tag = tag; e.run = r; e.sc = s; e.t = t; e.d = d; e.i = i; e.ovr = o;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Test 1 tables: T walk after start with ir=0000 (captures D=01 at T2).
    logic [7:0] walk_t [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    logic [7:0] walk_d [8] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};

    initial begin
        rst_n = 1'b0; start = 1'b0; hlt = 1'b0; sc_clr = 1'b0; ir = 16'h0000;
        #2;
        post("reset", 0, 0, 8'h00, 8'h00, 0, 0);

        // Test 1: start then free-running walk and overrun on wrap.
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            start = 1'b0;
            post($sformatf("walk_T%0d", k), 1, 3'(k), walk_t[k], walk_d[k], 0, 0);
        end
        step();
        post("wrap_overrun", 1, 0, 8'h01, 8'h01, 0, 1);

        // Test 2: ir=7000 before T2, sc_clr at T3.
        ir = 16'h7000;
        step(); post("t2_T1", 1, 1, 8'h02, 8'h01, 0, 1);
        step(); post("t2_T2", 1, 2, 8'h04, 8'h01, 0, 1);
        step(); post("t2_T3_capture", 1, 3, 8'h08, 8'h80, 0, 1);
        sc_clr = 1'b1;
        step(); post("t2_after_clr", 1, 0, 8'h01, 8'h80, 0, 1);
        sc_clr = 1'b0;
        step(); post("t2_hold_T1", 1, 1, 8'h02, 8'h80, 0, 1);
        step(); post("t2_hold_T2", 1, 2, 8'h04, 8'h80, 0, 1);

        // Test 3: ir=A123 at T2 -> D=04, I=1; ir change during T3 ignored.
        ir = 16'hA123;
        step(); post("t3_capture", 1, 3, 8'h08, 8'h04, 1, 1);
        ir = 16'h7FFF;

        // Test 4: hlt with sc_clr at T3, then restart.
        hlt = 1'b1; sc_clr = 1'b1;
        step(); post("t4_halted", 0, 0, 8'h00, 8'h04, 1, 1);
        hlt = 1'b0; sc_clr = 1'b0;
        step(); post("t4_idle", 0, 0, 8'h00, 8'h04, 1, 1);
        start = 1'b1;
        step(); post("t4_restart", 1, 0, 8'h01, 8'h04, 1, 0);
        start = 1'b0;

        // Test 5: hlt and start together while stopped.
        hlt = 1'b1;
        step(); post("t5_stop", 0, 0, 8'h00, 8'h04, 1, 0);
        start = 1'b1;
        step(); post("t5_hlt_start", 0, 0, 8'h00, 8'h04, 1, 0);
        hlt = 1'b0; start = 1'b0;
        step(); post("t5_still_idle", 0, 0, 8'h00, 8'h04, 1, 0);

        // Test 6: async reset mid-T5 with D=10.
        start = 1'b1;
        step(); post("t6_T0", 1, 0, 8'h01, 8'h04, 1, 0);
        start = 1'b0;
        ir = 16'h4000;
        step(); step(); step();
        post("t6_T3", 1, 3, 8'h08, 8'h10, 0, 0);
        step(); step();
        post("t6_T5", 1, 5, 8'h20, 8'h10, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        post("t6_async_reset", 0, 0, 8'h00, 8'h00, 0, 0);
        @(posedge clk);
        #1;
        post("t6_reset_hold", 0, 0, 8'h00, 8'h00, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(); post("t6_post_reset", 0, 0, 8'h00, 8'h00, 0, 0);

        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: bench still running at %0t, want finished", $time);
        $fatal(1, "watchdog");
    end

endmodule
